// File: rtl/axi_csr.sv
// AXI4-Lite control/status register block for the convolution engine.
// Decodes address bits [5:2] into the geometry, base-address and status registers.
module axi_csr #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 32
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [7:0]                        kernel_size,
   output logic [7:0]                        stride,
   output logic [7:0]                        padding,
   output logic                              has_bias,
   output logic                              has_relu,
   output logic                              conv_mode,
   output logic                              start,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     kernel_baseaddr,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     feature_baseaddr,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     output_baseaddr,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     feature_width,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     feature_height,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     feature_chin,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     feature_chout,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     output_width,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     output_height,
   input  logic                              running,
   input  logic                              compute_done,
   input  logic                              exception
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = C_S_AXI_DATA_WIDTH / 8;

   logic            r_aw_full;
   logic [3:0]      r_aw_idx;
   logic            r_w_full;
   logic [DW-1:0]   r_wdata;
   logic [SW-1:0]   r_wstrb;
   logic            r_bvalid;
   logic            r_rvalid;
   logic [DW-1:0]   r_rdata;
   logic            r_conv_mode;
   logic            r_has_bias;
   logic            r_has_relu;
   logic [7:0]      r_kernel_size;
   logic [7:0]      r_stride;
   logic [7:0]      r_padding;
   logic [DW-1:0]   r_cfg [1:9];
   logic            r_done;
   logic            r_exc;
   logic            r_start;

   logic            w_awready;
   logic            w_wready;
   logic            w_arready;
   logic            w_wr_en;
   logic            w_start_fire;
   logic            w_clr_done;
   logic            w_clr_exc;
   logic [3:0]      w_rd_idx;
   logic [DW-1:0]   w_ctrl_word;
   logic [DW-1:0]   w_ctrl_new;
   logic [DW-1:0]   w_status_word;
   logic [DW-1:0]   w_rd_word;
   logic            w_unused_bits;

   function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_v,
                                             input logic [DW-1:0] new_v,
                                             input logic [SW-1:0] strb);
      f_merge = old_v;
      for (int i = 0; i < SW; i++) begin
         if (strb[i]) f_merge[8*i +: 8] = new_v[8*i +: 8];
      end
   endfunction

   assign w_awready = !r_aw_full && !r_bvalid;
   assign w_wready  = !r_w_full && !r_bvalid;
   assign w_arready = !r_rvalid;
   assign w_wr_en   = r_aw_full && r_w_full;
   assign w_rd_idx  = S_AXI_ARADDR[5:2];

   // start bit is write-only, so it always reads back as 0
   assign w_ctrl_word   = {r_padding, r_stride, r_kernel_size, 4'b0000,
                           r_has_relu, r_has_bias, r_conv_mode, 1'b0};
   assign w_status_word = {{(DW-3){1'b0}}, r_exc, r_done, running};
   assign w_ctrl_new    = f_merge(w_ctrl_word, r_wdata, r_wstrb);

   assign w_start_fire = w_wr_en && (r_aw_idx == 4'd0) && r_wstrb[0] && r_wdata[0] && !running;
   assign w_clr_done   = w_wr_en && (r_aw_idx == 4'd10) && r_wstrb[0] && r_wdata[1];
   assign w_clr_exc    = w_wr_en && (r_aw_idx == 4'd10) && r_wstrb[0] && r_wdata[2];

   assign w_unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                            S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:6], S_AXI_AWADDR[1:0],
                            S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:6], S_AXI_ARADDR[1:0]};

   always_comb begin
      w_rd_word = '0;
      case (w_rd_idx)
         4'd0:    w_rd_word = w_ctrl_word;
         4'd10:   w_rd_word = w_status_word;
         default: if (w_rd_idx >= 4'd1 && w_rd_idx <= 4'd9) w_rd_word = r_cfg[w_rd_idx];
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         r_aw_full     <= 1'b0;
         r_aw_idx      <= '0;
         r_w_full      <= 1'b0;
         r_wdata       <= '0;
         r_wstrb       <= '0;
         r_bvalid      <= 1'b0;
         r_rvalid      <= 1'b0;
         r_rdata       <= '0;
         r_conv_mode   <= 1'b0;
         r_has_bias    <= 1'b0;
         r_has_relu    <= 1'b0;
         r_kernel_size <= '0;
         r_stride      <= '0;
         r_padding     <= '0;
         r_done        <= 1'b0;
         r_exc         <= 1'b0;
         r_start       <= 1'b0;
         for (int i = 1; i <= 9; i++) r_cfg[i] <= '0;
      end else begin
         if (w_awready && S_AXI_AWVALID) begin
            r_aw_full <= 1'b1;
            r_aw_idx  <= S_AXI_AWADDR[5:2];
         end
         if (w_wready && S_AXI_WVALID) begin
            r_w_full <= 1'b1;
            r_wdata  <= S_AXI_WDATA;
            r_wstrb  <= S_AXI_WSTRB;
         end

         // latches cannot refill while BVALID is high, so execute and B-clear never overlap
         if (w_wr_en) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_bvalid  <= 1'b1;
            case (r_aw_idx)
               4'd0: begin
                  r_conv_mode   <= w_ctrl_new[1];
                  r_has_bias    <= w_ctrl_new[2];
                  r_has_relu    <= w_ctrl_new[3];
                  r_kernel_size <= w_ctrl_new[15:8];
                  r_stride      <= w_ctrl_new[23:16];
                  r_padding     <= w_ctrl_new[31:24];
               end
               default: begin
                  if (r_aw_idx >= 4'd1 && r_aw_idx <= 4'd9)
                     r_cfg[r_aw_idx] <= f_merge(r_cfg[r_aw_idx], r_wdata, r_wstrb);
               end
            endcase
         end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
         end

         r_start <= w_start_fire;
         r_done  <= compute_done | (r_done & ~(w_clr_done | w_start_fire));
         r_exc   <= exception    | (r_exc  & ~(w_clr_exc  | w_start_fire));

         if (w_arready && S_AXI_ARVALID) begin
            r_rdata  <= w_rd_word;
            r_rvalid <= 1'b1;
         end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   assign S_AXI_AWREADY = w_awready;
   assign S_AXI_WREADY  = w_wready;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_ARREADY = w_arready;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = 2'b00;
   assign S_AXI_RVALID  = r_rvalid;

   assign kernel_size      = r_kernel_size;
   assign stride           = r_stride;
   assign padding          = r_padding;
   assign has_bias         = r_has_bias;
   assign has_relu         = r_has_relu;
   assign conv_mode        = r_conv_mode;
   assign start            = r_start;
   assign kernel_baseaddr  = r_cfg[1];
   assign feature_baseaddr = r_cfg[2];
   assign feature_width    = r_cfg[3];
   assign feature_height   = r_cfg[4];
   assign feature_chin     = r_cfg[5];
   assign feature_chout    = r_cfg[6];
   assign output_baseaddr  = r_cfg[7];
   assign output_width     = r_cfg[8];
   assign output_height    = r_cfg[9];

endmodule

// File: tb/tb_axi_csr.sv
// Bench for axi_csr: register-map model updated per completed write, checked every cycle,
// plus directed AXI transactions with hand-computed expected values.
`timescale 1ns/1ps
module tb_axi_csr;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [31:0] awaddr;  logic [2:0] awprot;  logic awvalid; logic awready;
   logic [31:0] wdata;   logic [3:0] wstrb;   logic wvalid;  logic wready;
   logic [1:0]  bresp;   logic bvalid;        logic bready;
   logic [31:0] araddr;  logic [2:0] arprot;  logic arvalid; logic arready;
   logic [31:0] rdata;   logic [1:0] rresp;   logic rvalid;  logic rready;
   logic [7:0]  kernel_size, stride, padding;
   logic        has_bias, has_relu, conv_mode, start;
   logic [31:0] kernel_baseaddr, feature_baseaddr, output_baseaddr;
   logic [31:0] feature_width, feature_height, feature_chin, feature_chout;
   logic [31:0] output_width, output_height;
   logic        running, compute_done, exception;

   axi_csr #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .kernel_size(kernel_size), .stride(stride), .padding(padding),
      .has_bias(has_bias), .has_relu(has_relu), .conv_mode(conv_mode), .start(start),
      .kernel_baseaddr(kernel_baseaddr), .feature_baseaddr(feature_baseaddr),
      .output_baseaddr(output_baseaddr),
      .feature_width(feature_width), .feature_height(feature_height),
      .feature_chin(feature_chin), .feature_chout(feature_chout),
      .output_width(output_width), .output_height(output_height),
      .running(running), .compute_done(compute_done), .exception(exception)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_start_cyc = -1;
   int pulse_cnt = 0;
   bit chk_en = 1'b0;

   // Model of the register map as seen by software
   logic [31:0] m_ctrl;
   logic [31:0] m_cfg [1:9];
   logic        m_done, m_exc;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (start) pulse_cnt <= pulse_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, act, want);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_read(input int idx);
      if (idx == 0)                return m_ctrl;
      if (idx >= 1 && idx <= 9)    return m_cfg[idx];
      if (idx == 10)               return {29'b0, m_exc, m_done, running};
      return 32'h0;
   endfunction

   task automatic model_reset();
      m_ctrl = 0; m_done = 0; m_exc = 0; exp_start_cyc = -1;
      for (int i = 1; i <= 9; i++) m_cfg[i] = 0;
   endtask

   task automatic model_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
      int idx;
      idx = int'(addr[5:2]);
      if (idx == 0) begin
         m_ctrl = merge(m_ctrl, d, s) & 32'hFFFF_FF0E;
         if (s[0] && d[0] && !running) begin
            exp_start_cyc = cyc;
            m_done = 0;
            m_exc  = 0;
         end
      end else if (idx >= 1 && idx <= 9) begin
         m_cfg[idx] = merge(m_cfg[idx], d, s);
      end else if (idx == 10 && s[0]) begin
         if (d[1]) m_done = 0;
         if (d[2]) m_exc  = 0;
      end
   endtask

   always @(negedge clk) begin : cmp
      logic [315:0] a_v, e_v;
      if (chk_en) begin
         a_v = {kernel_size, stride, padding, has_bias, has_relu, conv_mode, start,
                kernel_baseaddr, feature_baseaddr, feature_width, feature_height,
                feature_chin, feature_chout, output_baseaddr, output_width, output_height};
         e_v = {m_ctrl[15:8], m_ctrl[23:16], m_ctrl[31:24], m_ctrl[2], m_ctrl[3], m_ctrl[1],
                (cyc == exp_start_cyc),
                m_cfg[1], m_cfg[2], m_cfg[3], m_cfg[4], m_cfg[5], m_cfg[6],
                m_cfg[7], m_cfg[8], m_cfg[9]};
         checks++;
         if (a_v !== e_v) begin
            errors++;
            $display("FAIL outputs cyc=%0d got=%h want=%h", cyc, a_v, e_v);
         end
      end
   end

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] d,
                            input logic [3:0] s, input bit same);
      chk("awready_idle", awready, 1);
      chk("wready_idle", wready, 1);
      awaddr = addr; wdata = d; wstrb = s;
      if (same) begin
         awvalid = 1; wvalid = 1;
         @(posedge clk); #1;
         awvalid = 0; wvalid = 0;
      end else begin
         awvalid = 1;
         @(posedge clk); #1;
         awvalid = 0;
         chk("awready_latched", awready, 0);
         wvalid = 1;
         @(posedge clk); #1;
         wvalid = 0;
         chk("bvalid_before_exec", bvalid, 0);
      end
      @(posedge clk); #1;
      chk("bvalid_after_exec", bvalid, 1);
      chk("bresp", bresp, 0);
      model_write(addr, d, s);
      if (bready) begin
         @(posedge clk); #1;
         chk("bvalid_cleared", bvalid, 0);
      end
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] d);
      int n;
      n = 0;
      araddr = addr; arvalid = 1;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!rvalid && n < 20);
      arvalid = 0;
      if (!rvalid) begin
         errors++; checks++;
         $display("FAIL read_timeout addr=%h got=0 want=1", addr);
      end
      d = rdata;
      chk("rresp", rresp, 0);
      @(posedge clk); #1;
   endtask

   task automatic pulse_input(input bit is_exc);
      if (is_exc) exception = 1; else compute_done = 1;
      @(posedge clk); #1;
      exception = 0; compute_done = 0;
      if (is_exc) m_exc = 1; else m_done = 1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, lit, old;
      int p0;
      rst_n = 0; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
      bready = 1; araddr = 0; arprot = 0; arvalid = 0; rready = 1;
      running = 0; compute_done = 0; exception = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      chk_en = 1;
      chk("rst_awready", awready, 1);
      chk("rst_wready", wready, 1);
      chk("rst_arready", arready, 1);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_start", start, 0);

      // partial strobe on a zeroed register
      axi_write(32'h4000_000C, 32'h1234_5678, 4'b0011, 0);
      chk("strb_feature_width", feature_width, 32'h0000_5678);
      axi_read(32'h0000_000C, rd);
      chk("strb_readback", rd, 32'h0000_5678);

      // AW and W together
      axi_write(32'h0000_001C, 32'hA000_0000, 4'hF, 1);
      chk("same_cycle_obase", output_baseaddr, 32'hA000_0000);

      // all-ones sweep via aliased upper address bits
      p0 = pulse_cnt;
      for (int i = 0; i < 10; i++) axi_write(32'h4000_0000 + 32'(4*i), 32'hFFFF_FFFF, 4'hF, 0);
      @(negedge clk);
      chk("sweep_start_pulses", pulse_cnt - p0, 1);
      chk("sweep_kernel_size", kernel_size, 8'hFF);
      chk("sweep_stride", stride, 8'hFF);
      chk("sweep_padding", padding, 8'hFF);
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         axi_read(32'h4000_0000 + 32'(4*i), rd);
         lit = (i == 0) ? 32'hFFFF_FF0E : 32'hFFFF_FFFF;
         chk("sweep_read_lit", rd, lit);
         chk("sweep_read_model", rd, m_read(i));
      end

      // unmapped offset
      axi_write(32'h0000_0030, 32'hFFFF_FFFF, 4'hF, 0);
      axi_read(32'h0000_0030, rd);
      chk("unmapped_read", rd, 0);

      // status sticky bits, W1C, start gating
      pulse_input(0);
      axi_read(32'h28, rd);  chk("status_done", rd, 32'h2);
      axi_write(32'h28, 32'h2, 4'hF, 0);
      axi_read(32'h28, rd);  chk("status_w1c", rd, 32'h0);
      pulse_input(1);
      running = 1;
      axi_read(32'h28, rd);  chk("status_exc_run", rd, 32'h5);
      p0 = pulse_cnt;
      axi_write(32'h0, 32'h1, 4'hF, 0);
      @(negedge clk);
      chk("no_start_when_running", pulse_cnt - p0, 0);
      @(posedge clk); #1;
      axi_read(32'h28, rd);  chk("status_kept", rd, 32'h5);
      running = 0;
      p0 = pulse_cnt;
      axi_write(32'h0, 32'h1, 4'hF, 0);
      @(negedge clk);
      chk("start_when_idle", pulse_cnt - p0, 1);
      @(posedge clk); #1;
      axi_read(32'h28, rd);  chk("start_clears_status", rd, 32'h0);

      // back-pressure on B
      bready = 0;
      axi_write(32'h10, 32'h0000_00AB, 4'hF, 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bhold_bvalid", bvalid, 1);
         chk("bhold_awready", awready, 0);
      end
      bready = 1;
      @(posedge clk); #1;
      chk("bhold_release", bvalid, 0);
      chk("bhold_awready_back", awready, 1);

      // read sampled on the same edge as a write to the same register
      old = m_read(1);
      awaddr = 32'h04; wdata = 32'h55AA_55AA; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0; araddr = 32'h04; arvalid = 1;
      @(posedge clk); #1;
      arvalid = 0;
      chk("conc_bvalid", bvalid, 1);
      chk("conc_rvalid", rvalid, 1);
      chk("conc_prewrite_lit", rdata, 32'hFFFF_FFFF);
      chk("conc_prewrite_model", rdata, old);
      model_write(32'h04, 32'h55AA_55AA, 4'hF);
      @(posedge clk); #1;
      chk("conc_done_b", bvalid, 0);
      chk("conc_done_r", rvalid, 0);
      chk("conc_new_value", kernel_baseaddr, 32'h55AA_55AA);

      // reset between AW and W aborts the write
      awaddr = 32'h08; awvalid = 1;
      @(posedge clk); #1;
      awvalid = 0; rst_n = 0;
      @(posedge clk); #1;
      model_reset();
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("abort_no_bvalid", bvalid, 0);
      end
      chk("abort_fbase", feature_baseaddr, 0);
      for (int i = 0; i < 11; i++) begin
         axi_read(32'(4*i), rd);
         chk("abort_read_zero", rd, 0);
      end
      axi_write(32'h08, 32'hDEAD_BEEF, 4'hF, 0);
      axi_read(32'h08, rd);
      chk("post_reset_write", rd, 32'hDEAD_BEEF);

      repeat (3) @(posedge clk);
      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_csr.md
AXI_CSR -- requirements
Module: axi_csr

Interface
REQ-001 Parameters: C_S_AXI_DATA_WIDTH, default 32 (`DATA_WIDTH), data bus width; C_S_AXI_ADDR_WIDTH, default 32 (`CSR_ADDR_WIDTH), address bus width.
REQ-002 Ports, in order `name  direction  width  meaning`:
- S_AXI_ACLK  in  1  the single clock.
- S_AXI_ARESETN  in  1  reset, synchronous, active-low.
- S_AXI_AWADDR/AWPROT/AWVALID  in  ADDR/3/1  write address channel; AWPROT ignored.
- S_AXI_AWREADY  out  1  write-address ready.
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1  write data channel.
- S_AXI_WREADY  out  1  write-data ready.
- S_AXI_BRESP/BVALID  out  2/1  write response.
- S_AXI_BREADY  in  1  response ready.
- S_AXI_ARADDR/ARPROT/ARVALID  in  ADDR/3/1  read address channel; ARPROT ignored.
- S_AXI_ARREADY  out  1  read-address ready.
- S_AXI_RDATA/RRESP/RVALID  out  32/2/1  read data channel.
- S_AXI_RREADY  in  1  read data ready.
- kernel_size, stride, padding  out  8 each  convolution geometry.
- has_bias, has_relu, conv_mode  out  1 each  mode flags.
- start  out  1  one-cycle launch pulse.
- kernel_baseaddr, feature_baseaddr, output_baseaddr  out  32 each  base addresses.
- feature_width, feature_height, feature_chin, feature_chout, output_width, output_height  out  32 each  dimensions.
- running, compute_done, exception  in  1 each  engine status.

Function
REQ-003 Register decode SHALL use address bits [5:2]; bits [1:0] and all bits above [5] are ignored, so 0x40000000 selects offset 0x00.
REQ-004 Register map:
- 0x00 CTRL: [0] start (write-only, reads 0); [1] conv_mode; [2] has_bias; [3] has_relu; [15:8] kernel_size; [23:16] stride; [31:24] padding; bits [7:4] read 0.
- 0x04 kernel_baseaddr.
- 0x08 feature_baseaddr.
- 0x0C feature_width.
- 0x10 feature_height.
- 0x14 feature_chin.
- 0x18 feature_chout.
- 0x1C output_baseaddr.
- 0x20 output_width.
- 0x24 output_height.
- 0x28 STATUS: [0] running (live, RO); [1] done (sticky, W1C); [2] exception (sticky, W1C); other bits read 0.
REQ-005 Unmapped offsets (0x2C-0x3C) SHALL read 0, ignore writes, and respond OKAY.
REQ-006 Each output port SHALL be driven directly from its register field.
REQ-007 Write byte lanes SHALL honour WSTRB: byte i is updated only when WSTRB[i]=1.
REQ-008 AW and W SHALL be accepted independently, in either order or in the same cycle:
- AWREADY = no address latched and BVALID=0.
- WREADY = no data latched and BVALID=0.
- Each is captured on VALID&READY.
REQ-009 With both address and data latched, the register write SHALL occur on the next rising edge. That same edge sets BVALID=1 and BRESP=00 and clears both latches.
REQ-010 BVALID SHALL hold until BREADY=1 and clear on that edge.
REQ-011 ARREADY SHALL equal (RVALID=0). On AR handshake, the next edge SHALL register RDATA and set RVALID=1 with RRESP=00.
REQ-012 RDATA and RVALID SHALL hold until RREADY=1.
REQ-013 A read and a write in flight concurrently SHALL both complete. A read of a register written on the same edge returns the pre-write value.
REQ-014 start SHALL pulse high for exactly one cycle, on the edge a CTRL write executes with WSTRB[0]=1 and WDATA[0]=1, but only when running=0; otherwise no pulse.
REQ-015 STATUS.done SHALL set when compute_done=1, and STATUS.exception SHALL set when exception=1.
REQ-016 Each sticky bit SHALL clear on a STATUS write with a 1 in its position. If set and clear coincide, set wins.
REQ-017 The start pulse SHALL also clear done and exception unless they are set on the same edge.

Reset
REQ-018 While S_AXI_ARESETN=0 at a rising edge, every register, output, and handshake flag SHALL go to 0 (AWREADY/WREADY/ARREADY follow their equations, giving 1). Pending transactions are discarded.
REQ-019 Reset asserted mid-transaction SHALL abort it: no register update and no B/R response afterwards.

Verification
REQ-020 Write 0xFFFFFFFF to 0x40000000..0x40000024, each as AW then W in separate cycles, BREADY=1; then read each. Required results:
- 0x00 reads 0xFFFFFF0E; kernel_size, stride and padding = 0xFF.
- 0x04-0x24 read 0xFFFFFFFF.
- start pulses once.
- BRESP and RRESP = 00.
REQ-021 Write 0x12345678 to 0x0C with WSTRB=0011 after the register holds 0 -> feature_width=0x00005678.
REQ-022 AW and W presented in the same cycle to 0x1C with data 0xA0000000 -> output_baseaddr=0xA0000000 and BVALID one cycle later.
REQ-023 Hold BREADY=0 for 5 cycles after a write -> BVALID stays 1 and AWREADY stays 0 until BREADY rises.
REQ-024 Pulse compute_done for 1 cycle -> STATUS reads 0x2. Write 0x2 to 0x28 -> STATUS reads 0x0. Write CTRL=0x1 with running=1 -> no start pulse.
REQ-025 Assert reset after AW handshake but before W -> no BVALID; all outputs read 0; a subsequent write completes normally.
